// File: rtl/joy_scan_pkg.sv
// Shared types and sizing helpers for the serial joystick scanner.
// Used by joy_serial_scan and its optional JOY_SCAN_DEBOUNCE_EN debounce stage.
package joy_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOW,
        ST_HIGH,
        ST_COMMIT,
        ST_GAP
    } state_t;

    // Width able to hold 0..n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int scan_period(
        input int half,
        input int bits_n,
        input int gap
    );
        return half + 2 * half * bits_n + 1 + gap;
    endfunction

endpackage

// File: rtl/joy_scan_debounce.sv
// Two-scan agreement register: a bit follows the chain only when
// two consecutive scans report the same value for it.
module joy_scan_debounce
    import joy_scan_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] raw,
    output logic [W-1:0] q
);

    logic [W-1:0] prev;
    logic [W-1:0] agree;
    logic         primed;

    assign agree = ~(raw ^ prev);

    always_ff @(posedge clk_sys) begin
        if (reset || clear) begin
            prev   <= '0;
            primed <= 1'b0;
            q      <= '0;
        end else if (load) begin
            prev   <= raw;
            primed <= 1'b1;
            // first scan after a clear only fills history
            if (primed) begin
                q <= (q & ~agree) | (raw & agree);
            end
        end
    end

endmodule

// File: rtl/joy_serial_scan.sv
// Serial-shift (74HC165-style) joystick chain reader, PLAYERS x BITS.
// Define JOY_SCAN_DEBOUNCE_EN to require two agreeing scans per bit change.
module joy_serial_scan
    import joy_scan_pkg::*;
#(
    parameter int PLAYERS = 2,
    parameter int BITS    = 12,
    parameter int HALF    = 21,
    parameter int GAP     = 420
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      joy_data,
    output logic                      joy_clk,
    output logic                      joy_load,
    output logic [PLAYERS*BITS-1:0]   joystick,
    output logic                      frame_stb
);

    localparam int N  = PLAYERS * BITS;
    localparam int HW = cnt_w(HALF);
    localparam int KW = cnt_w(N);
    localparam int GW = cnt_w(GAP);

    localparam logic [HW-1:0] H_LAST = HW'(HALF - 1);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [GW-1:0] G_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t        state;
    logic [HW-1:0] hcnt;
    logic [KW-1:0] k;
    logic [GW-1:0] gcnt;
    logic [N-1:0]  shift;
    logic          sync1;
    logic          sync2;
    logic          commit_go;

    assign commit_go = enable && (state == ST_COMMIT);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= joy_data;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || !enable) begin
            state     <= ST_IDLE;
            hcnt      <= '0;
            k         <= '0;
            gcnt      <= '0;
            shift     <= '0;
            joy_clk   <= 1'b0;
            joy_load  <= 1'b1;
            frame_stb <= 1'b0;
        end else begin
            frame_stb <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    state    <= ST_LOAD;
                    hcnt     <= '0;
                    joy_load <= 1'b0;
                end
                ST_LOAD: begin
                    if (hcnt == H_LAST) begin
                        state    <= ST_LOW;
                        hcnt     <= '0;
                        k        <= '0;
                        joy_load <= 1'b1;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (hcnt == H_LAST) begin
                        shift[k] <= sync2;
                        state    <= ST_HIGH;
                        hcnt     <= '0;
                        joy_clk  <= 1'b1;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (hcnt == H_LAST) begin
                        hcnt    <= '0;
                        joy_clk <= 1'b0;
                        if (k == K_LAST) begin
                            state <= ST_COMMIT;
                        end else begin
                            k     <= k + 1'b1;
                            state <= ST_LOW;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    frame_stb <= 1'b1;
                    k         <= '0;
                    gcnt      <= '0;
                    if (GAP == 0) begin
                        state    <= ST_LOAD;
                        joy_load <= 1'b0;
                    end else begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gcnt == G_LAST) begin
                        state    <= ST_LOAD;
                        gcnt     <= '0;
                        joy_load <= 1'b0;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef JOY_SCAN_DEBOUNCE_EN
    joy_scan_debounce #(
        .W(N)
    ) u_debounce (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clear   (!enable),
        .load    (commit_go),
        .raw     (~shift),
        .q       (joystick)
    );
`else
    always_ff @(posedge clk_sys) begin
        if (reset || !enable) begin
            joystick <= '0;
        end else if (commit_go) begin
            joystick <= ~shift;
        end
    end
`endif

endmodule

// File: tb/tb_joy_serial_scan.sv
// Scoreboard bench for joy_serial_scan with a behavioural 74HC165 chain.
// Works for the raw build and for JOY_SCAN_DEBOUNCE_EN.
module tb_joy_serial_scan;
    import joy_scan_pkg::*;

    localparam int PLAYERS = 2;
    localparam int BITS    = 12;
    localparam int HALF    = 3;
    localparam int GAP     = 4;
    localparam int N       = PLAYERS * BITS;
    localparam int PERIOD  = 152;
    localparam int LAT     = 148;

    logic          clk_sys;
    logic          reset;
    logic          enable;
    logic          joy_data;
    logic          joy_clk;
    logic          joy_load;
    logic [N-1:0]  joystick;
    logic          frame_stb;

    joy_serial_scan #(
        .PLAYERS(PLAYERS),
        .BITS   (BITS),
        .HALF   (HALF),
        .GAP    (GAP)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .enable   (enable),
        .joy_data (joy_data),
        .joy_clk  (joy_clk),
        .joy_load (joy_load),
        .joystick (joystick),
        .frame_stb(frame_stb)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    logic [N-1:0] raw_chain = '1;
    logic [N-1:0] sh_m = '1;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] prev_m = '0;
    logic [N-1:0] out_m = '0;
    logic         primed_m = 1'b0;

    int  cyc = 0;
    int  load_fall_cyc = 0;
    int  last_cyc = 0;
    bit  last_valid = 0;
    int  rise_cnt = 0;
    int  load_low = 0;
    int  frame_cnt = 0;
    logic prev_load = 1'b1;
    logic prev_clk = 1'b0;

    assign joy_data = sh_m[0];

    task automatic set_buttons(input logic [N-1:0] v);
        raw_chain = ~v;
    endtask

    task automatic push_expected();
        logic [N-1:0] v;
        logic [N-1:0] agree;
        v = ~raw_chain;
`ifdef JOY_SCAN_DEBOUNCE_EN
        agree = ~(v ^ prev_m);
        if (primed_m) out_m = (out_m & ~agree) | (v & agree);
        prev_m   = v;
        primed_m = 1'b1;
        exp_q.push_back(out_m);
`else
        agree = '0;
        exp_q.push_back(v | agree);
`endif
    endtask

    task automatic flush();
        exp_q.delete();
        prev_m     = '0;
        out_m      = '0;
        primed_m   = 1'b0;
        last_valid = 0;
    endtask

    // chain model, scoreboard pop and per-scan timing checks
    always @(posedge clk_sys) begin
        logic [N-1:0] e;
        #1;
        cyc++;
        if (!joy_load) begin
            sh_m = raw_chain;
            if (prev_load) begin
                push_expected();
                load_fall_cyc = cyc;
                rise_cnt = 0;
                load_low = 0;
            end
            load_low++;
        end else if (joy_clk && !prev_clk) begin
            sh_m = {1'b1, sh_m[N-1:1]};
            rise_cnt++;
        end
        if (frame_stb) begin
            chk("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("joystick", joystick, e);
            end
            chk("rises", rise_cnt, N);
            chk("load_w", load_low, HALF);
            chk("latency", cyc - load_fall_cyc, LAT);
            if (last_valid) chk("period", cyc - last_cyc, PERIOD);
            last_cyc   = cyc;
            last_valid = 1;
            frame_cnt++;
        end
        prev_load = joy_load;
        prev_clk  = joy_clk;
    end

    task automatic wait_frames(input int n);
        int target;
        int t;
        target = frame_cnt + n;
        t = 0;
        while (frame_cnt < target && t < n * 400) begin
            @(negedge clk_sys);
            t++;
        end
        chk("frames", frame_cnt, target);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_clk"}, joy_clk, 0);
        chk({tag, "_load"}, joy_load, 1);
        chk({tag, "_joy"}, joystick, 0);
        chk({tag, "_stb"}, frame_stb, 0);
    endtask

    initial begin
        int t;
        int fc;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_idle("rst");
        chk("period_fn", scan_period(HALF, N, GAP), PERIOD);

        reset = 1'b0;
        set_buttons(24'h5A3C0F);
        enable = 1'b1;
        wait_frames(3);

        set_buttons(24'h000000);
        wait_frames(2);
        set_buttons(24'h800000);
        wait_frames(2);

        // abort while bit 10 is being shifted
        set_buttons(24'hA5F00F);
        t = 0;
        while (!(rise_cnt == 10 && !joy_clk && joy_load) && t < 400) begin
            @(negedge clk_sys);
            t++;
        end
        chk("bit10_wait", rise_cnt, 10);
        fc = frame_cnt;
        enable = 1'b0;
        @(negedge clk_sys);
        check_idle("abort");
        chk("abort_frames", frame_cnt, fc);
        flush();
        enable = 1'b1;
        wait_frames(2);

        // reset during a high phase with enable held
        set_buttons(24'h13579B);
        t = 0;
        while (!joy_clk && t < 400) begin
            @(negedge clk_sys);
            t++;
        end
        chk("high_wait", joy_clk, 1);
        reset = 1'b1;
        @(negedge clk_sys);
        check_idle("midrst");
        reset = 1'b0;
        flush();
        wait_frames(2);

        // bit 0 toggling every scan, then held
        set_buttons(24'h000000);
        wait_frames(2);
        for (int i = 0; i < 4; i++) begin
            set_buttons((i % 2 == 0) ? 24'h000001 : 24'h000000);
            wait_frames(1);
`ifdef JOY_SCAN_DEBOUNCE_EN
            chk("db_alt", joystick[0], 0);
`endif
        end
        set_buttons(24'h000001);
        wait_frames(1);
`ifdef JOY_SCAN_DEBOUNCE_EN
        chk("db_hold1", joystick[0], 0);
`endif
        wait_frames(1);
        chk("hold2", joystick[0], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
